// File: rtl/z80_ind_jump_seq_pkg.sv
// rtl/z80_ind_jump_seq_pkg.sv - shared z80 types for the JP (HL) sequencer
// Holds the sequencer state enum, trace widths and the wait-counter width helper.
package z80_ind_jump_seq_pkg;

   localparam int Z80_ADDR_W   = 16;
   localparam int Z80_DATA_W   = 8;
   localparam int TR_ADDR_W    = Z80_ADDR_W;
   localparam int TR_DATA_W    = Z80_DATA_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD_LO = 2'd1,
      ST_RD_HI = 2'd2,
      ST_DONE  = 2'd3
   } jp_state_t;

   // Width needed to hold 0..timeout, never narrower than one bit.
   function automatic int wait_cnt_w(input int timeout);
      int w;
      w = (timeout > 0) ? $clog2(timeout + 1) : 1;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/z80_ind_jump_seq_wait_timer.sv
// rtl/z80_ind_jump_seq_wait_timer.sv - saturating per-read wait counter
// Ports: clk, reset (async, active-high), clr (restart count), en (count a
// wait cycle), expired (this wait cycle is the TIMEOUT-th one; never with TIMEOUT=0).
module z80_wait_timer #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != {CW{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

   // Flag the cycle whose increment would bring the count to TIMEOUT, so the
   // FSM can abort on the same edge instead of one cycle later.
   generate
      if (TIMEOUT > 0) begin : g_timeout
         assign expired = en && (count == LAST);
      end else begin : g_no_timeout
         assign expired = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/z80_ind_jump_seq.sv
// rtl/z80_ind_jump_seq.sv - JP (HL) sequencer: reads a 16-bit target from (HL) and loads IP
// Ports: clk, reset (async, active-high); start/hl_in request; busy status;
// mem_req/mem_addr/mem_ack/mem_rdata byte-read port; ip_wr/ip_out IP load;
// err timeout strobe; tr_raddr/tr_raddr2/tr_rdata/tr_rdata2 read trace.
module z80_ind_jump_seq
   import z80_ind_jump_seq_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [15:0]          hl_in,
   output logic                 busy,
   output logic                 mem_req,
   output logic [15:0]          mem_addr,
   input  logic                 mem_ack,
   input  logic [7:0]           mem_rdata,
   output logic                 ip_wr,
   output logic [15:0]          ip_out,
   output logic                 err,
   output logic [TR_ADDR_W-1:0] tr_raddr,
   output logic [TR_ADDR_W-1:0] tr_raddr2,
   output logic [TR_DATA_W-1:0] tr_rdata,
   output logic [TR_DATA_W-1:0] tr_rdata2
);

   localparam int CW = wait_cnt_w(TIMEOUT);

   jp_state_t   state;
   logic [15:0] addr_q;
   logic [7:0]  lo_q;
   logic [7:0]  hi_q;
   logic        in_rd;
   logic        tmr_clr;
   logic        tmr_en;
   logic        tmr_expired;

   assign in_rd   = (state == ST_RD_LO) || (state == ST_RD_HI);
   // Restart the count outside reads and on the RD_LO -> RD_HI hand-over.
   assign tmr_clr = !in_rd || ((state == ST_RD_LO) && mem_ack);
   assign tmr_en  = in_rd && !mem_ack;

   z80_wait_timer #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   assign busy      = (state != ST_IDLE);
   // The high byte only changes on the edge that enters DONE, so it can
   // drive the trace directly and still hold between operations.
   assign tr_rdata2 = hi_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         ip_wr     <= 1'b0;
         ip_out    <= '0;
         err       <= 1'b0;
         tr_raddr  <= '0;
         tr_raddr2 <= '0;
         tr_rdata  <= '0;
      end else begin
         ip_wr <= 1'b0;
         err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr_q   <= hl_in;
                  mem_req  <= 1'b1;
                  mem_addr <= hl_in;
                  state    <= ST_RD_LO;
               end
            end
            ST_RD_LO: begin
               if (mem_ack) begin
                  lo_q     <= mem_rdata;
                  mem_addr <= addr_q + 16'd1;
                  state    <= ST_RD_HI;
               end else if (tmr_expired) begin
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            ST_RD_HI: begin
               if (mem_ack) begin
                  hi_q      <= mem_rdata;
                  mem_req   <= 1'b0;
                  ip_wr     <= 1'b1;
                  ip_out    <= {mem_rdata, lo_q};
                  tr_raddr  <= addr_q;
                  tr_raddr2 <= mem_addr;
                  tr_rdata  <= lo_q;
                  state     <= ST_DONE;
               end else if (tmr_expired) begin
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_z80_ind_jump_seq.sv
// tb/tb_z80_ind_jump_seq.sv - self-checking bench for z80_ind_jump_seq
module tb_z80_ind_jump_seq;

   localparam int TIMEOUT = 16;
   localparam int NEVER   = 255;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] hl_in;
   logic        busy;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        ip_wr;
   logic [15:0] ip_out;
   logic        err;
   logic [15:0] tr_raddr;
   logic [15:0] tr_raddr2;
   logic [7:0]  tr_rdata;
   logic [7:0]  tr_rdata2;

   int n_tests;
   int n_fail;

   logic [7:0] mem [0:65535];
   int         waits [0:1];
   int         rd_no;
   int         waited;
   bit         force_ack;

   z80_ind_jump_seq #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .hl_in     (hl_in),
      .busy      (busy),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ip_wr     (ip_wr),
      .ip_out    (ip_out),
      .err       (err),
      .tr_raddr  (tr_raddr),
      .tr_raddr2 (tr_raddr2),
      .tr_rdata  (tr_rdata),
      .tr_rdata2 (tr_rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: acks the current read after waits[rd_no] idle cycles,
   // and sprinkles stray acks with junk data while no request is pending.
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (force_ack) begin
         mem_ack   = 1'b1;
         mem_rdata = 8'($urandom);
      end else if (mem_req && !reset) begin
         if (waited >= waits[(rd_no > 1) ? 1 : rd_no]) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            waited    = 0;
            rd_no     = rd_no + 1;
         end else begin
            waited    = waited + 1;
            mem_rdata = 8'($urandom);
         end
      end else begin
         waited = 0;
         if ($urandom_range(0, 3) == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'($urandom);
         end
      end
   end

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [83:0] all_outs();
      return {busy, mem_req, ip_wr, err, mem_addr, ip_out,
              tr_raddr, tr_raddr2, tr_rdata, tr_rdata2};
   endfunction

   // One JP (HL) with w0/w1 wait cycles on the two reads; NEVER means no ack.
   task automatic run_op(input string tag, input logic [15:0] hl, input int w0, input int w1);
      int          exp_lat;
      bit          exp_err;
      int          cyc;
      int          addr_bad;
      int          req_bad;
      bit          got_wr;
      bit          got_err;
      logic [15:0] a1;
      logic [15:0] exp_addr;
      a1 = hl + 16'd1;
      if (w0 >= TIMEOUT) begin
         exp_err = 1'b1;
         exp_lat = 1 + TIMEOUT;
      end else if (w1 >= TIMEOUT) begin
         exp_err = 1'b1;
         exp_lat = w0 + 2 + TIMEOUT;
      end else begin
         exp_err = 1'b0;
         exp_lat = w0 + w1 + 3;
      end
      waits[0] = w0;
      waits[1] = w1;
      rd_no    = 0;
      addr_bad = 0;
      req_bad  = 0;
      got_wr   = 1'b0;
      got_err  = 1'b0;
      cyc      = 0;
      @(negedge clk);
      start = 1'b1;
      hl_in = hl;
      while (!(got_wr || got_err) && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         start = 1'b0;
         got_wr  = ip_wr;
         got_err = err;
         if (!(ip_wr || err)) begin
            exp_addr = (cyc <= w0 + 1) ? hl : a1;
            if (!mem_req) req_bad++;
            else if (mem_addr !== exp_addr) addr_bad++;
         end
      end
      check_eq({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
      check_eq({tag, "_outcome"}, {got_err, got_wr}, exp_err ? 2'b10 : 2'b01);
      check_eq({tag, "_addr"}, 128'(addr_bad), 0);
      check_eq({tag, "_req"}, 128'(req_bad), 0);
      if (!exp_err) begin
         check_eq({tag, "_ip_out"}, ip_out, {mem[a1], mem[hl]});
         check_eq({tag, "_trace"}, {tr_raddr, tr_raddr2, tr_rdata, tr_rdata2},
                  {hl, a1, mem[hl], mem[a1]});
      end
      @(posedge clk);
      #1;
      check_eq({tag, "_after"}, {busy, ip_wr, err}, 3'b000);
   endtask

   task automatic reset_mid_op();
      int bad;
      waits[0] = 0;
      waits[1] = NEVER;
      rd_no    = 0;
      @(negedge clk);
      start = 1'b1;
      hl_in = 16'h5A5A;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check_eq("rst_mid_busy", {busy, mem_req, mem_addr}, {2'b11, 16'h5A5B});
      reset = 1'b1;
      #1;
      check_eq("rst_mid_outs", all_outs(), 84'd0);
      @(negedge clk);
      reset = 1'b0;
      force_ack = 1'b1;
      bad = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         force_ack = 1'b0;
         if (ip_wr || err || busy || mem_req) bad++;
      end
      check_eq("rst_late_ack", 128'(bad), 0);
   endtask

   task automatic back_to_back();
      logic [15:0] q_exp [$];
      logic [15:0] h;
      logic [15:0] e;
      int          n_wr;
      waits[0] = 0;
      waits[1] = 0;
      n_wr     = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         start = (c < 10);
         h     = 16'($urandom);
         hl_in = h;
         // At zero wait each operation occupies four cycles, so starts are
         // taken at cycles 0, 4, 8 and ignored in between.
         if (c < 10 && (c % 4) == 0) begin
            q_exp.push_back({mem[h + 16'd1], mem[h]});
            rd_no = 0;
         end
         @(posedge clk);
         #1;
         if (ip_wr) begin
            e = (q_exp.size() > 0) ? q_exp.pop_front() : 16'hxxxx;
            check_eq("b2b_ip_out", ip_out, e);
            check_eq("b2b_wr_cycle", 128'(c + 1), 128'(4 * n_wr + 3));
            n_wr++;
         end
      end
      start = 1'b0;
      check_eq("b2b_count", 128'(n_wr), 3);
   endtask

   initial begin
      int w0;
      int w1;
      int sel;
      n_tests   = 0;
      n_fail    = 0;
      start     = 1'b0;
      hl_in     = 16'h0000;
      force_ack = 1'b0;
      waits[0]  = 0;
      waits[1]  = 0;
      rd_no     = 0;
      waited    = 0;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      reset     = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h1234] = 8'hCD;
      mem[16'h1235] = 8'hAB;
      mem[16'hFFFF] = 8'h00;
      mem[16'h0000] = 8'h80;

      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_outs", all_outs(), 84'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_eq("idle_after_reset", {busy, mem_req, ip_wr, err}, 4'b0000);

      run_op("basic", 16'h1234, 0, 0);
      check_eq("basic_value", ip_out, 16'hABCD);
      run_op("wrap", 16'hFFFF, 0, 0);
      check_eq("wrap_value", {tr_raddr2, ip_out}, {16'h0000, 16'h8000});
      run_op("waits2", 16'h4000, 2, 2);
      run_op("to_hi", 16'h2222, 1, NEVER);
      run_op("to_lo", 16'h3333, NEVER, 0);
      run_op("edge_ok", 16'h7777, TIMEOUT - 1, TIMEOUT - 1);
      run_op("edge_to", 16'h8888, 0, TIMEOUT);
      check_eq("hold_after_err", ip_out, {mem[16'h7778], mem[16'h7777]});

      reset_mid_op();
      run_op("post_rst", 16'h1234, 0, 0);
      check_eq("post_rst_value", ip_out, 16'hABCD);

      back_to_back();

      for (int k = 0; k < 30; k++) begin
         sel = $urandom_range(0, 9);
         w0  = (sel == 9) ? NEVER : ((sel == 8) ? TIMEOUT - 1 : $urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         w1  = (sel == 9) ? TIMEOUT : ((sel == 8) ? TIMEOUT - 1 : $urandom_range(0, 3));
         run_op("rand", 16'($urandom), w0, w1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/z80_ind_jump_seq.md
Z80_IND_JUMP_SEQ -- requirements
Module: z80_ind_jump_seq

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of wait cycles per memory read; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to execute JP (HL); sampled only in IDLE.
REQ-005 hl_in  input  16  HL value; captured on an accepted start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 mem_req  output  1  byte-read request to the shared memory port.
REQ-008 mem_addr  output  16  read address; valid while mem_req is high.
REQ-009 mem_ack  input  1  read-complete strobe; mem_rdata is valid in the same cycle.
REQ-010 mem_rdata  input  8  read data.
REQ-011 ip_wr  output  1  one-cycle strobe that loads ip_out into IP.
REQ-012 ip_out  output  16  new IP, {high byte, low byte}.
REQ-013 err  output  1  one-cycle strobe on read timeout.
REQ-014 tr_raddr, tr_raddr2  output  16 each  trace: addresses of read 1 and read 2.
REQ-015 tr_rdata, tr_rdata2  output  8 each  trace: data of read 1 and read 2; all trace outputs are valid when ip_wr is high.

Function
REQ-016 States are IDLE, RD_LO, RD_HI and DONE, encoded as an enum.
REQ-017 IDLE: start=1 captures hl_in into addr_q and moves to RD_LO on the next cycle; start=0 stays in IDLE.
REQ-018 RD_LO: mem_req=1 and mem_addr=addr_q; mem_ack=1 latches mem_rdata into lo_q and moves to RD_HI.
REQ-019 RD_HI: mem_req=1 and mem_addr=addr_q+1, truncated to 16 bits (0xFFFF wraps to 0x0000); mem_ack=1 latches into hi_q and moves to DONE.
REQ-020 DONE: ip_wr=1 for exactly one cycle and ip_out={hi_q,lo_q}, then IDLE; start in DONE is ignored.
REQ-021 mem_req and mem_addr are registered and held stable from request until the acked cycle inclusive; mem_req=0 in IDLE and DONE.
REQ-022 mem_ack while mem_req=0 is ignored.
REQ-023 The minimum latency from start to ip_wr is 3 cycles (ack in the first cycle of each read); each extra wait cycle adds 1.
REQ-024 The wait counter clears on entry to each RD state and increments every RD cycle without ack.
REQ-025 When TIMEOUT>0 and the counter reaches TIMEOUT without ack: err=1 for one cycle, the FSM returns to IDLE, and ip_wr is not asserted.
REQ-026 Counter width is $clog2(TIMEOUT+1) with a minimum of 1 bit, and it saturates rather than wrapping.
REQ-027 A start held high across a completed operation begins a new operation in the cycle after the return to IDLE.
REQ-028 ip_out and the trace outputs hold their last values outside DONE.

Reset
REQ-029 reset forces IDLE with busy=0, mem_req=0, ip_wr=0 and err=0; mem_addr, ip_out, the trace outputs, lo_q, hi_q, addr_q and the counter are all 0.
REQ-030 Reset asserted mid-operation aborts it immediately, with no ip_wr and no err; a late mem_ack after reset is ignored.

Structure
REQ-031 The state enum and the trace-signal widths belong in the shared z80 package/header alongside the existing z80 defines.
REQ-032 One sub-module is natural: z80_wait_timer, a saturating wait counter with clear, enable and expired outputs, parameterised by TIMEOUT.
REQ-033 The block itself is a single FSM plus datapath registers with no combinational path from mem_ack to mem_req.

Verification
REQ-034 hl_in=0x1234, mem[0x1234]=0xCD, mem[0x1235]=0xAB, zero-wait acks -> mem_addr 0x1234 then 0x1235; ip_wr 3 cycles after start with ip_out=0xABCD.
REQ-035 hl_in=0xFFFF, mem[0xFFFF]=0x00, mem[0x0000]=0x80 -> second address 0x0000; ip_out=0x8000.
REQ-036 hl_in=0x4000, 2 wait cycles on each read -> mem_addr stable during the waits; ip_wr at cycle 7; trace outputs 0x4000/0x4001 with matching data.
REQ-037 TIMEOUT=16, no ack on RD_HI -> err pulse after 16 wait cycles, then IDLE; no ip_wr; busy=0 afterwards.
REQ-038 reset pulse during RD_HI, followed by a late ack -> all outputs 0; no ip_wr; the next start behaves as in REQ-034.
REQ-039 start held high for 10 cycles -> back-to-back operations, each with a single ip_wr; start is ignored while busy=1.
